// File: rtl/bkm_pipe_scoreboard.sv
// In-order scoreboard for the BKM step pipeline: CSD-to-binary conversion, expected-result FIFO, compare and counters.
// Optional tolerance compare on X/Y enabled by defining BKM_MON_TOL_EN.
module bkm_pipe_scoreboard #(
  parameter int unsigned WD    = 72,
  parameter int unsigned WC    = 22,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned TOL   = 1
) (
  input  logic                   clk,
  input  logic                   srst,
  input  logic                   enable,
  input  logic                   dut_valid,
  input  logic [2*WD-1:0]        X_np1_csd,
  input  logic [2*WD-1:0]        Y_np1_csd,
  input  logic [WC-1:0]          u_np1_bin,
  input  logic [WC-1:0]          v_np1_bin,
  input  logic                   exp_valid,
  input  logic [WD-1:0]          exp_X,
  input  logic [WD-1:0]          exp_Y,
  input  logic [WC-1:0]          exp_u,
  input  logic [WC-1:0]          exp_v,
  output logic [WD-1:0]          X_np1_bin,
  output logic [WD-1:0]          Y_np1_bin,
  output logic                   cmp_valid,
  output logic                   cmp_pass,
  output logic [31:0]            err_cnt,
  output logic [31:0]            smp_cnt,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   ovf_err,
  output logic                   unf_err,
  output logic                   csd_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

`ifdef BKM_MON_TOL_EN
  localparam int unsigned TOL_LIM = TOL;
`else
  // Zero tolerance reduces the X/Y check to an exact match.
  localparam int unsigned TOL_LIM = 0 * TOL;
`endif

  typedef struct packed {
    logic [WD-1:0] x;
    logic [WD-1:0] y;
    logic [WC-1:0] u;
    logic [WC-1:0] v;
  } exp_t;

  // Digit pair 11 contributes 0; result spans WD+1 signed bits.
  function automatic logic [WD:0] csd2bin(input logic [2*WD-1:0] d);
    logic [WD-1:0] p;
    logic [WD-1:0] n;
    for (int i = 0; i < int'(WD); i++) begin
      p[i] = d[2*i+1] & ~d[2*i];
      n[i] = d[2*i]   & ~d[2*i+1];
    end
    return {1'b0, p} - {1'b0, n};
  endfunction

  function automatic logic csd_bad_pair(input logic [2*WD-1:0] d);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < int'(WD); i++) bad = bad | (d[2*i+1] & d[2*i]);
    return bad;
  endfunction

  function automatic logic [WD:0] abs_diff(input logic [WD-1:0] a, input logic [WD-1:0] b);
    logic [WD:0] d;
    d = {a[WD-1], a} - {b[WD-1], b};
    return d[WD] ? -d : d;
  endfunction

  logic [WD:0]   w_x_full;
  logic [WD:0]   w_y_full;
  logic          w_csd_fault;
  logic          w_sample;
  logic          r_vld_s1;
  logic [WC-1:0] r_u_s1;
  logic [WC-1:0] r_v_s1;

  exp_t          r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  exp_t          w_head;
  exp_t          w_entry;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_match;

  always_comb begin
    w_x_full    = csd2bin(X_np1_csd);
    w_y_full    = csd2bin(Y_np1_csd);
    w_sample    = enable & dut_valid;
    w_csd_fault = csd_bad_pair(X_np1_csd) | csd_bad_pair(Y_np1_csd) |
                  (w_x_full[WD] ^ w_x_full[WD-1]) | (w_y_full[WD] ^ w_y_full[WD-1]);
  end

  // Stage 1: capture converted DUT sample; holds while enable is low.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_vld_s1  <= 1'b0;
      X_np1_bin <= '0;
      Y_np1_bin <= '0;
      r_u_s1    <= '0;
      r_v_s1    <= '0;
      csd_err   <= 1'b0;
    end else begin
      r_vld_s1 <= w_sample;
      if (w_sample) begin
        X_np1_bin <= w_x_full[WD-1:0];
        Y_np1_bin <= w_y_full[WD-1:0];
        r_u_s1    <= u_np1_bin;
        r_v_s1    <= v_np1_bin;
        if (w_csd_fault) csd_err <= 1'b1;
      end
    end
  end

  // Pop uses the registered level, so a same-cycle push is never visible to the compare.
  always_comb begin
    w_entry = '{x: exp_X, y: exp_Y, u: exp_u, v: exp_v};
    w_head  = r_mem[r_rd_ptr];
    w_empty = (fifo_level == '0);
    w_full  = (fifo_level == LW'(DEPTH));
    w_pop   = r_vld_s1 & ~w_empty;
    w_push  = exp_valid & (~w_full | w_pop);
    w_match = (abs_diff(X_np1_bin, w_head.x) <= (WD+1)'(TOL_LIM)) &&
              (abs_diff(Y_np1_bin, w_head.y) <= (WD+1)'(TOL_LIM)) &&
              (r_u_s1 == w_head.u) && (r_v_s1 == w_head.v);
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_entry;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      fifo_level <= '0;
      ovf_err    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      fifo_level <= fifo_level + LW'(w_push) - LW'(w_pop);
      if (exp_valid && !w_push) ovf_err <= 1'b1;
    end
  end

  // Stage 2: compare against FIFO head; an empty FIFO counts as a failed compare.
  always_ff @(posedge clk) begin
    if (srst) begin
      cmp_valid <= 1'b0;
      cmp_pass  <= 1'b0;
      err_cnt   <= '0;
      smp_cnt   <= '0;
      unf_err   <= 1'b0;
    end else begin
      cmp_valid <= r_vld_s1;
      cmp_pass  <= w_pop & w_match;
      if (r_vld_s1) begin
        if (smp_cnt != '1) smp_cnt <= smp_cnt + 32'd1;
        if (!(w_pop && w_match) && err_cnt != '1) err_cnt <= err_cnt + 32'd1;
        if (w_empty) unf_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bkm_pipe_scoreboard.sv
// Directed self-checking bench for bkm_pipe_scoreboard (default parameters).
module tb_bkm_pipe_scoreboard;

  localparam int unsigned WD = 72;
  localparam int unsigned WC = 22;

  logic            clk;
  logic            srst;
  logic            enable;
  logic            dut_valid;
  logic [2*WD-1:0] X_np1_csd;
  logic [2*WD-1:0] Y_np1_csd;
  logic [WC-1:0]   u_np1_bin;
  logic [WC-1:0]   v_np1_bin;
  logic            exp_valid;
  logic [WD-1:0]   exp_X;
  logic [WD-1:0]   exp_Y;
  logic [WC-1:0]   exp_u;
  logic [WC-1:0]   exp_v;
  logic [WD-1:0]   X_np1_bin;
  logic [WD-1:0]   Y_np1_bin;
  logic            cmp_valid;
  logic            cmp_pass;
  logic [31:0]     err_cnt;
  logic [31:0]     smp_cnt;
  logic [4:0]      fifo_level;
  logic            ovf_err;
  logic            unf_err;
  logic            csd_err;

  int n_chk;
  int n_fail;

  bkm_pipe_scoreboard #(.WD(WD), .WC(WC), .DEPTH(16), .TOL(1)) dut (
    .clk(clk), .srst(srst), .enable(enable), .dut_valid(dut_valid),
    .X_np1_csd(X_np1_csd), .Y_np1_csd(Y_np1_csd),
    .u_np1_bin(u_np1_bin), .v_np1_bin(v_np1_bin),
    .exp_valid(exp_valid), .exp_X(exp_X), .exp_Y(exp_Y), .exp_u(exp_u), .exp_v(exp_v),
    .X_np1_bin(X_np1_bin), .Y_np1_bin(Y_np1_bin),
    .cmp_valid(cmp_valid), .cmp_pass(cmp_pass),
    .err_cnt(err_cnt), .smp_cnt(smp_cnt), .fifo_level(fifo_level),
    .ovf_err(ovf_err), .unf_err(unf_err), .csd_err(csd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WD-1:0] sx(input int v);
    return WD'(v);
  endfunction

  // Positive values use +1 digits, negative values use -1 digits.
  function automatic logic [2*WD-1:0] csd_of(input int v);
    logic [2*WD-1:0] r;
    int a;
    r = '0;
    a = (v < 0) ? -v : v;
    for (int i = 0; i < 31; i++) begin
      if (a[i]) begin
        if (v < 0) r[2*i] = 1'b1;
        else       r[2*i+1] = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic set_exp(input int x, input int y, input int u, input int v);
    exp_X = sx(x); exp_Y = sx(y); exp_u = WC'(u); exp_v = WC'(v);
  endtask

  task automatic set_dut(input int x, input int y, input int u, input int v);
    X_np1_csd = csd_of(x); Y_np1_csd = csd_of(y); u_np1_bin = WC'(u); v_np1_bin = WC'(v);
  endtask

  task automatic do_reset();
    srst = 1'b1;
    tick();
    srst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (X_np1_bin !== '0 || Y_np1_bin !== '0) begin n_fail++; $display("FAIL reset_xy got %0h/%0h want 0", X_np1_bin, Y_np1_bin); end
    n_chk++; if ({cmp_valid, cmp_pass} !== 2'b00) begin n_fail++; $display("FAIL reset_cmp got %b want 00", {cmp_valid, cmp_pass}); end
    n_chk++; if (err_cnt !== 32'd0 || smp_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_cnt got %0d/%0d want 0/0", err_cnt, smp_cnt); end
    n_chk++; if (fifo_level !== 5'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", fifo_level); end
    n_chk++; if ({ovf_err, unf_err, csd_err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {ovf_err, unf_err, csd_err}); end
  endtask

  task automatic test_basic();
    int passes;
    logic want;
    do_reset();
    set_exp(5, -3, 1, 0);
    exp_valid = 1'b1;
    repeat (4) tick();
    exp_valid = 1'b0;
    n_chk++; if (fifo_level !== 5'd4) begin n_fail++; $display("FAIL basic_fill got %0d want 4", fifo_level); end
    set_dut(5, -3, 1, 0);
    dut_valid = 1'b1;
    passes = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k == 3) dut_valid = 1'b0;
      if (k == 0) begin
        n_chk++; if (X_np1_bin !== sx(5) || Y_np1_bin !== sx(-3)) begin n_fail++; $display("FAIL basic_conv got %0h/%0h want 5/-3", X_np1_bin, Y_np1_bin); end
      end
      want = (k >= 1 && k <= 4);
      n_chk++; if (cmp_valid !== want || cmp_pass !== want) begin n_fail++; $display("FAIL basic_pulse cyc %0d got %b%b want %b%b", k, cmp_valid, cmp_pass, want, want); end
      if (cmp_valid && cmp_pass) passes++;
    end
    n_chk++; if (passes !== 4) begin n_fail++; $display("FAIL basic_passes got %0d want 4", passes); end
    n_chk++; if (smp_cnt !== 32'd4 || err_cnt !== 32'd0) begin n_fail++; $display("FAIL basic_cnt got smp %0d err %0d want 4/0", smp_cnt, err_cnt); end
    n_chk++; if (fifo_level !== 5'd0 || csd_err !== 1'b0) begin n_fail++; $display("FAIL basic_end got level %0d csd %b want 0/0", fifo_level, csd_err); end
  endtask

  task automatic test_mismatch();
    logic want_pass6;
    logic [31:0] want_err;
`ifdef BKM_MON_TOL_EN
    want_pass6 = 1'b1;
`else
    want_pass6 = 1'b0;
`endif
    do_reset();
    for (int t = 0; t < 2; t++) begin
      set_exp(5, -3, 1, 0);
      exp_valid = 1'b1;
      tick();
      exp_valid = 1'b0;
      set_dut((t == 0) ? 6 : 7, -3, 1, 0);
      dut_valid = 1'b1;
      tick();
      dut_valid = 1'b0;
      tick();
      want_err = (t == 0) ? 32'(!want_pass6) : 32'(!want_pass6) + 32'd1;
      n_chk++; if (cmp_valid !== 1'b1 || cmp_pass !== ((t == 0) ? want_pass6 : 1'b0)) begin n_fail++; $display("FAIL mismatch_x%0d got v%b p%b want v1 p%b", (t == 0) ? 6 : 7, cmp_valid, cmp_pass, (t == 0) ? want_pass6 : 1'b0); end
      n_chk++; if (err_cnt !== want_err) begin n_fail++; $display("FAIL mismatch_err%0d got %0d want %0d", t, err_cnt, want_err); end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    set_exp(5, -3, 1, 0);
    exp_valid = 1'b1;
    repeat (16) tick();
    exp_valid = 1'b0;
    n_chk++; if (fifo_level !== 5'd16 || ovf_err !== 1'b0) begin n_fail++; $display("FAIL ovf_full got level %0d ovf %b want 16/0", fifo_level, ovf_err); end
    set_dut(5, -3, 1, 0);
    dut_valid = 1'b1;
    tick();
    dut_valid = 1'b0;
    exp_valid = 1'b1;
    tick();
    exp_valid = 1'b0;
    n_chk++; if (fifo_level !== 5'd16 || ovf_err !== 1'b0) begin n_fail++; $display("FAIL ovf_pushpop got level %0d ovf %b want 16/0", fifo_level, ovf_err); end
    n_chk++; if (cmp_valid !== 1'b1 || cmp_pass !== 1'b1) begin n_fail++; $display("FAIL ovf_cmp got %b%b want 11", cmp_valid, cmp_pass); end
    exp_valid = 1'b1;
    tick();
    exp_valid = 1'b0;
    n_chk++; if (fifo_level !== 5'd16 || ovf_err !== 1'b1) begin n_fail++; $display("FAIL ovf_drop got level %0d ovf %b want 16/1", fifo_level, ovf_err); end
  endtask

  task automatic test_underflow();
    do_reset();
    set_dut(5, -3, 1, 0);
    dut_valid = 1'b1;
    tick();
    dut_valid = 1'b0;
    set_exp(5, -3, 1, 0);
    exp_valid = 1'b1;
    tick();
    exp_valid = 1'b0;
    n_chk++; if (cmp_valid !== 1'b1 || cmp_pass !== 1'b0) begin n_fail++; $display("FAIL unf_cmp got %b%b want 10", cmp_valid, cmp_pass); end
    n_chk++; if (unf_err !== 1'b1 || err_cnt !== 32'd1) begin n_fail++; $display("FAIL unf_flag got unf %b err %0d want 1/1", unf_err, err_cnt); end
    n_chk++; if (fifo_level !== 5'd1) begin n_fail++; $display("FAIL unf_level got %0d want 1", fifo_level); end
  endtask

  task automatic test_csd();
    logic [WD-1:0] want_top;
    do_reset();
    set_exp(5, -3, 1, 0);
    exp_valid = 1'b1;
    tick();
    exp_valid = 1'b0;
    set_dut(0, -3, 1, 0);
    X_np1_csd[5:0] = 6'b10_11_10;
    dut_valid = 1'b1;
    tick();
    dut_valid = 1'b0;
    n_chk++; if (csd_err !== 1'b1 || X_np1_bin !== sx(5)) begin n_fail++; $display("FAIL csd_pair got err %b x %0h want 1/5", csd_err, X_np1_bin); end
    tick();
    n_chk++; if (cmp_pass !== 1'b1 || unf_err !== 1'b0) begin n_fail++; $display("FAIL csd_cmp got pass %b unf %b want 1/0", cmp_pass, unf_err); end
    do_reset();
    set_dut(0, 0, 0, 0);
    X_np1_csd[2*WD-1] = 1'b1;
    want_top = '0;
    want_top[WD-1] = 1'b1;
    dut_valid = 1'b1;
    tick();
    dut_valid = 1'b0;
    n_chk++; if (csd_err !== 1'b1 || X_np1_bin !== want_top) begin n_fail++; $display("FAIL csd_range got err %b x %0h want 1/%0h", csd_err, X_np1_bin, want_top); end
    tick();
  endtask

  task automatic test_srst_mid();
    do_reset();
    set_exp(5, -3, 1, 0);
    exp_valid = 1'b1;
    repeat (3) tick();
    exp_valid = 1'b0;
    set_dut(5, -3, 1, 0);
    dut_valid = 1'b1;
    tick();
    srst = 1'b1;
    exp_valid = 1'b1;
    tick();
    n_chk++; if (X_np1_bin !== '0 || Y_np1_bin !== '0 || cmp_valid !== 1'b0 || cmp_pass !== 1'b0) begin n_fail++; $display("FAIL srst_out got x %0h y %0h v%b p%b want 0", X_np1_bin, Y_np1_bin, cmp_valid, cmp_pass); end
    n_chk++; if (fifo_level !== 5'd0 || smp_cnt !== 32'd0 || err_cnt !== 32'd0) begin n_fail++; $display("FAIL srst_state got level %0d smp %0d err %0d want 0", fifo_level, smp_cnt, err_cnt); end
    srst = 1'b0;
    exp_valid = 1'b0;
    dut_valid = 1'b0;
    tick();
    n_chk++; if (cmp_valid !== 1'b0 || fifo_level !== 5'd0) begin n_fail++; $display("FAIL srst_ignore got v%b level %0d want 0/0", cmp_valid, fifo_level); end
    set_exp(2, 1, 3, 2);
    exp_valid = 1'b1;
    tick();
    exp_valid = 1'b0;
    set_dut(2, 1, 3, 2);
    dut_valid = 1'b1;
    tick();
    dut_valid = 1'b0;
    tick();
    n_chk++; if (cmp_valid !== 1'b1 || cmp_pass !== 1'b1) begin n_fail++; $display("FAIL srst_fresh got %b%b want 11", cmp_valid, cmp_pass); end
    n_chk++; if (smp_cnt !== 32'd1 || err_cnt !== 32'd0 || fifo_level !== 5'd0) begin n_fail++; $display("FAIL srst_fresh_cnt got smp %0d err %0d level %0d want 1/0/0", smp_cnt, err_cnt, fifo_level); end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    srst = 1'b1;
    enable = 1'b1;
    dut_valid = 1'b0;
    exp_valid = 1'b0;
    set_dut(0, 0, 0, 0);
    set_exp(0, 0, 0, 0);
    tick();
    test_reset();
    test_basic();
    test_mismatch();
    test_overflow();
    test_underflow();
    test_csd();
    test_srst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
